t11_toggle_event_receiver: RTL and testbench
============================================

# t11_toggle_event_receiver

Receiving end of the toggle-encoded event link. The sender is a toggle flip-flop that inverts its output line once per event. This block samples that line, turns each level change back into one event, and holds a saturating count of pending events. A downstream consumer drains the count through a valid/ready handshake. The block sits in the consumer's clock domain, at the far end of the toggle line.

## Interface
- CNT_W, 4: width of the pending-event counter; it saturates at 2^CNT_W-1.
- TOT_W, 16: width of the free-running total-event counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- tog_in  input  1  toggle line from the sender; its level is 0 while the sender is in reset.
- evt_valid  output  1  high when at least one event is pending.
- evt_ready  input  1  consumer accepts one event in any cycle with evt_valid & evt_ready.
- pend_cnt  output  CNT_W  number of events pending.
- tot_cnt  output  TOT_W  events detected since reset; wraps modulo 2^TOT_W.
- ovf  output  1  sticky flag: an event was dropped because pend_cnt was saturated.
- ovf_clr  input  1  clears ovf.

## Operation
- Input chain: N sample flops. N is 1 without the sync macro and 3 with it.
- Edge detect: last_lvl holds the previous value of the final chain stage. evt = stage[N-1] ^ last_lvl. last_lvl <= stage[N-1] every cycle.
- acc = evt_valid & evt_ready.
- pend_cnt update on each edge:
  - evt & !acc: +1, unless pend_cnt == max. At max it holds and ovf <= 1.
  - !evt & acc: -1.
  - evt & acc: unchanged, including at max. No overflow is flagged.
  - neither: unchanged.
- evt_ready while evt_valid is 0 has no effect. pend_cnt never underflows.
- tot_cnt increments on every evt, including dropped ones. It wraps from all-ones to 0.
- ovf: set has priority over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Reset: chain, last_lvl, pend_cnt, tot_cnt and ovf all go to 0. evt_valid = 0 during and right after reset.
- Reset mid-operation discards pending events. The sender is reset together with this block, so no spurious event follows reset.
- Toggles on tog_in closer together than one clock are not guaranteed to be detected. The sender guarantees at least 2 clocks between toggles.

## Timing
- tog_in changes before edge k. stage[0] updates at edge k.
- pend_cnt/evt_valid update after edge k+N: k+1 without sync, k+3 with sync. tot_cnt updates at the same edge.
- A handshake in cycle j is reflected in pend_cnt after edge j+1.
- evt_valid, pend_cnt, tot_cnt and ovf are all registered outputs; none is combinational from the inputs.
- Throughput: one event detected per clock and one accepted per clock.

## Configuration
- TOGGLE_RX_SYNC_EN defined: two extra synchronizer flops go in front of the sample flop (N=3). Use this when tog_in comes from an asynchronous domain.
- Not defined: a single sample flop (N=1). The sender must share clk.
- Port list and the counter/handshake behaviour are identical either way; only latency differs.

## Structure
- Package t11_toggle_pkg holds:
  - CNT_W_DEF and TOT_W_DEF defaults;
  - SYNC_STAGES constant, 3 or 1 depending on TOGGLE_RX_SYNC_EN;
  - max-count helper function.
- Sub-module t11_toggle_edge_det contains the sample chain, last_lvl and evt generation. Parent keeps the counters, handshake and ovf.

## Test plan
- Reset, tog_in = 0, evt_ready = 0 for 10 cycles -> evt_valid = 0, pend_cnt = 0, tot_cnt = 0, ovf = 0.
- Three toggles spaced 4 cycles apart, evt_ready = 0 -> pend_cnt = 3 and tot_cnt = 3. Each increment arrives exactly N cycles after its toggle.
- Then evt_ready = 1 -> evt_valid high for exactly 3 cycles; pend_cnt steps 3, 2, 1, 0.
- 17 toggles with evt_ready = 0 and CNT_W = 4 -> pend_cnt saturates at 15, ovf = 1, tot_cnt = 17.
- Assert ovf_clr on the same edge as a dropped event -> ovf stays 1. ovf_clr one cycle later -> ovf = 0.
- With pend_cnt = 15: detection and acceptance in the same cycle -> pend_cnt stays 15, ovf is not set.
- Assert rst with pend_cnt = 5 -> all outputs 0 the cycle after; toggles after reset count again from 1.
- tot_cnt with TOT_W = 4: 16 toggles -> tot_cnt wraps to 0.

Source files
------------

// File: rtl/t11_toggle_pkg.sv
// Shared constants and helpers for the toggle-encoded event receiver.
// TOGGLE_RX_SYNC_EN selects a 3-flop input chain (async sender) vs 1 flop.
package t11_toggle_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int TOT_W_DEF = 16;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 1;
`endif

    // Largest value a w-bit unsigned counter can hold.
    function automatic longint unsigned max_cnt(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/t11_toggle_edge_det.sv
// Sample chain plus level-change detector for the toggle line.
// Ports: clk_i, rst_i (sync, active-high), tog_i (toggle line), evt_o (one event).
module t11_toggle_edge_det
    import t11_toggle_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic tog_i,
    output logic evt_o
);

    logic [SYNC_STAGES-1:0] stage_q;
    logic                   last_lvl_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q    <= '0;
            last_lvl_q <= 1'b0;
        end else begin
            stage_q[0] <= tog_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            last_lvl_q <= stage_q[SYNC_STAGES-1];
        end
    end

    // Any level change on the last stage is exactly one sender event.
    assign evt_o = stage_q[SYNC_STAGES-1] ^ last_lvl_q;

endmodule

// File: rtl/t11_toggle_event_receiver.sv
// Toggle-link receiver: turns level changes into events, keeps a saturating
// pending count drained by valid/ready, a wrapping total and a sticky overflow.
// Ports: clk, rst (sync, active-high), tog_in, evt_valid, evt_ready,
//        pend_cnt, tot_cnt, ovf, ovf_clr. Macro: TOGGLE_RX_SYNC_EN.
module t11_toggle_event_receiver
    import t11_toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOT_W = TOT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [TOT_W-1:0] tot_cnt,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cnt(CNT_W));

    logic             evt;
    logic             acc;
    logic             ovf_set;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [TOT_W-1:0] tot_q, tot_d;
    logic             ovf_q, ovf_d;

    t11_toggle_edge_det u_edge (
        .clk_i (clk),
        .rst_i (rst),
        .tog_i (tog_in),
        .evt_o (evt)
    );

    assign acc = evt_valid & evt_ready;

    always_comb begin
        pend_d  = pend_q;
        ovf_set = 1'b0;
        tot_d   = tot_q + TOT_W'(evt);
        // A simultaneous detect and accept cancels out, even when saturated.
        if (evt && !acc) begin
            if (pend_q == CNT_MAX) begin
                ovf_set = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (!evt && acc) begin
            pend_d = pend_q - CNT_W'(1);
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            tot_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tot_q  <= tot_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_valid = (pend_q != '0);
    assign pend_cnt  = pend_q;
    assign tot_cnt   = tot_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_t11_toggle_event_receiver.sv
// Self-checking bench for t11_toggle_event_receiver (default and TOT_W=4 copies).
// Behavioural model: scheduled event arrivals plus integer counters.
module tb_t11_toggle_event_receiver;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int N = 3;
`else
    localparam int N = 1;
`endif
    localparam int PMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tog_in = 1'b0;
    logic evt_ready = 1'b0;
    logic ovf_clr = 1'b0;

    logic        evt_valid, evt_valid_s;
    logic [3:0]  pend_cnt, pend_cnt_s;
    logic [15:0] tot_cnt;
    logic [3:0]  tot_cnt_s;
    logic        ovf, ovf_s;

    always #5 clk = ~clk;

    t11_toggle_event_receiver dut (
        .clk(clk), .rst(rst), .tog_in(tog_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .pend_cnt(pend_cnt), .tot_cnt(tot_cnt),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    t11_toggle_event_receiver #(.CNT_W(4), .TOT_W(4)) dut_s (
        .clk(clk), .rst(rst), .tog_in(tog_in),
        .evt_valid(evt_valid_s), .evt_ready(evt_ready),
        .pend_cnt(pend_cnt_s), .tot_cnt(tot_cnt_s),
        .ovf(ovf_s), .ovf_clr(ovf_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  cyc = 0;
    int  arrivals[$];
    bit  prev_tog = 0;
    int  m_pend = 0;
    int  m_tot = 0;
    bit  m_ovf = 0;
    bit  armed = 0;

    always @(posedge clk) begin
        bit e, a, s;
        cyc++;
        if (rst) begin
            arrivals.delete();
            prev_tog = 0;
            m_pend = 0;
            m_tot = 0;
            m_ovf = 0;
            armed = 1;
        end else begin
            e = 0;
            if (arrivals.size() > 0 && arrivals[0] == cyc) begin
                e = 1;
                void'(arrivals.pop_front());
            end
            a = (m_pend > 0) && evt_ready;
            s = 0;
            m_tot = (m_tot + int'(e)) % 65536;
            if (e && !a) begin
                if (m_pend == PMAX) s = 1;
                else m_pend++;
            end else if (!e && a) begin
                m_pend--;
            end
            m_ovf = s ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            // a level change sampled now surfaces N edges later
            if (tog_in != prev_tog) arrivals.push_back(cyc + N);
            prev_tog = tog_in;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("evt_valid", evt_valid, m_pend != 0);
            chk("pend_cnt", pend_cnt, m_pend);
            chk("tot_cnt", tot_cnt, m_tot);
            chk("ovf", ovf, m_ovf);
            chk("s_pend_cnt", pend_cnt_s, m_pend);
            chk("s_tot_cnt", tot_cnt_s, m_tot % 16);
            chk("s_ovf", ovf_s, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic toggles(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tog_in = ~tog_in;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vcnt;
        int rp;
        int gap;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_tot", tot_cnt, 0);
        chk("rst_ovf", ovf, 0);

        // three toggles, first one with latency pinned
        tog_in = ~tog_in;
        repeat (N) @(negedge clk);
        chk("lat_before", pend_cnt, 0);
        @(negedge clk);
        chk("lat_after", pend_cnt, 1);
        repeat (4 - (N + 1)) @(negedge clk);
        toggles(2, 4);
        repeat (N + 2) @(negedge clk);
        chk("three_pend", pend_cnt, 3);
        chk("three_tot", tot_cnt, 3);

        // drain
        evt_ready = 1'b1;
        vcnt = 0;
        repeat (8) begin
            if (evt_valid) vcnt++;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        chk("drain_valid_cycles", vcnt, 3);
        chk("drain_pend", pend_cnt, 0);

        // saturation
        do_reset();
        toggles(17, 2);
        repeat (N + 2) @(negedge clk);
        chk("sat_pend", pend_cnt, 15);
        chk("sat_ovf", ovf, 1);
        chk("sat_tot", tot_cnt, 17);
        chk("sat_tot_s", tot_cnt_s, 1);

        // ovf_clr coinciding with a dropped event loses to the set
        tog_in = ~tog_in;
        repeat (N) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_vs_set_ovf", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_ovf", ovf, 0);
        repeat (2) @(negedge clk);

        // detect and accept together at saturation
        tog_in = ~tog_in;
        repeat (N) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("sat_both_pend", pend_cnt, 15);
        chk("sat_both_ovf", ovf, 0);

        // reset mid-operation with 5 pending
        do_reset();
        toggles(5, 2);
        repeat (N + 2) @(negedge clk);
        chk("pre_rst_pend", pend_cnt, 5);
        rst = 1'b1;
        tog_in = 1'b0;
        @(negedge clk);
        chk("mid_rst_pend", pend_cnt, 0);
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_tot", tot_cnt, 0);
        rst = 1'b0;
        tog_in = ~tog_in;
        repeat (N + 1) @(negedge clk);
        chk("post_rst_pend", pend_cnt, 1);
        chk("post_rst_tot", tot_cnt, 1);

        // total wrap on the 4-bit copy
        do_reset();
        evt_ready = 1'b1;
        toggles(16, 2);
        repeat (N + 2) @(negedge clk);
        chk("wrap_tot_s", tot_cnt_s, 0);
        chk("wrap_tot", tot_cnt, 16);
        evt_ready = 1'b0;

        // randomized traffic
        rp = 50;
        gap = 2;
        for (int c = 0; c < 6000; c++) begin
            if (c % 400 == 0) begin
                case ($urandom_range(0, 2))
                    0: rp = 5;
                    1: rp = 50;
                    default: rp = 95;
                endcase
            end
            evt_ready = ($urandom_range(0, 99) < rp);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1;
                tog_in = 1'b0;
                gap = 0;
            end else begin
                rst = 1'b0;
                if (gap >= 2 && $urandom_range(0, 2) == 0) begin
                    tog_in = ~tog_in;
                    gap = 0;
                end
                gap++;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        repeat (N + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
